// File: rtl/nf10_rx_dst_tagger_if.sv
// AXI4-Stream bundle used by nf10_rx_dst_tagger on both its input and output side.
//   tdata  : beat payload, C_AXIS_DATA_WIDTH bits
//   tstrb  : byte strobes, one bit per tdata byte
//   tuser  : sideband, [15:0] length, [23:16] src port, [31:24] dst port, rest reserved
//   tvalid : source has a beat
//   tlast  : final beat of a packet
//   tready : sink can take the beat
// master drives the payload and tvalid; slave drives tready.
interface nf10_rx_dst_tagger_if #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128
) ();
  logic [C_AXIS_DATA_WIDTH-1:0]   tdata;
  logic [C_AXIS_DATA_WIDTH/8-1:0] tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0]  tuser;
  logic                           tvalid;
  logic                           tlast;
  logic                           tready;

  modport master (
    output tdata, tstrb, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tuser, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/nf10_rx_dst_tagger.sv
// Receive-side destination tagger. Looks at the destination MAC of each packet's first beat,
// picks a one-hot destination port code (host DMA, plus physical ports for multicast/broadcast),
// writes it into tuser[31:24] of every beat of the packet, or drops the whole packet when the
// frame is unicast to someone else and promiscuous mode is off. Output is one register stage.
// Ports:
//   axi_aclk, axi_reset : clock, asynchronous active-high reset
//   s_axis              : input packet stream (slave side)
//   m_axis              : tagged output stream (master side)
//   promisc             : forward foreign unicast instead of dropping (sampled on header beats)
//   pkt_count           : packets accepted on s_axis (forwarded or dropped)
//   drop_count          : packets dropped
module nf10_rx_dst_tagger #(
  parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
  parameter logic [47:0] C_MAC_ADDR         = 48'h000000000000,
  parameter logic [7:0]  C_HOST_DST_PORT    = 8'h02,
  parameter logic [7:0]  C_PHYS_PORT_MASK   = 8'h55
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  nf10_rx_dst_tagger_if.slave   s_axis,
  nf10_rx_dst_tagger_if.master  m_axis,
  input  logic                  promisc,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
);

  typedef enum logic [1:0] {StHeader, StPass, StDrop} state_e;

  state_e state_q, state_d;

  logic [C_AXIS_DATA_WIDTH-1:0]   out_tdata_q;
  logic [C_AXIS_DATA_WIDTH/8-1:0] out_tstrb_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]  out_tuser_q;
  logic [C_AXIS_TUSER_WIDTH-1:0]  out_tuser_d;
  logic                           out_valid_q;
  logic                           out_last_q;
  logic [7:0]                     dst_q;
  logic [31:0]                    pkt_count_q;
  logic [31:0]                    drop_count_q;

  logic [47:0] rx_mac;
  logic        is_mcast;
  logic        hdr_drop;
  logic [7:0]  hdr_dst;
  logic        in_ready;
  logic        in_xfer;
  logic        drop_beat;
  logic        load;
  logic [7:0]  beat_dst;

  // Header classification. The MAC arrives wire byte 0 first in tdata[7:0]; reorder it so it
  // compares directly against C_MAC_ADDR, which keeps wire byte 0 in bits 47:40.
  always_comb begin
    rx_mac = '0;
    for (int i = 0; i < 6; i++) begin
      rx_mac[47-8*i -: 8] = s_axis.tdata[8*i +: 8];
    end
    // Broadcast has the group bit set, so it falls under the multicast rule.
    is_mcast = s_axis.tdata[0];
    hdr_drop = 1'b0;
    if (is_mcast) begin
      hdr_dst = C_HOST_DST_PORT | (C_PHYS_PORT_MASK & ~s_axis.tuser[23:16]);
    end else if ((rx_mac == C_MAC_ADDR) || promisc) begin
      hdr_dst = C_HOST_DST_PORT;
    end else begin
      hdr_dst  = 8'h00;
      hdr_drop = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q <= StHeader;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    if (in_xfer) begin
      unique case (state_q)
        StHeader: begin
          if (!s_axis.tlast) begin
            state_d = hdr_drop ? StDrop : StPass;
          end
        end
        StPass, StDrop: begin
          if (s_axis.tlast) begin
            state_d = StHeader;
          end
        end
        default: state_d = StHeader;
      endcase
    end
  end

  // FSM outputs: handshake and per-beat decisions.
  always_comb begin
    // Dropped beats never touch the output register, so they can be swallowed even when stalled.
    in_ready  = (state_q == StDrop) || !out_valid_q || m_axis.tready;
    in_xfer   = s_axis.tvalid && in_ready;
    drop_beat = (state_q == StDrop) || ((state_q == StHeader) && hdr_drop);
    load      = in_xfer && !drop_beat;
    beat_dst  = (state_q == StHeader) ? hdr_dst : dst_q;
  end

  always_comb begin
    out_tuser_d        = s_axis.tuser;
    out_tuser_d[31:24] = beat_dst;
  end

  // Output register stage, destination hold register and counters.
  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_tdata_q  <= '0;
      out_tstrb_q  <= '0;
      out_tuser_q  <= '0;
      dst_q        <= 8'h00;
      pkt_count_q  <= 32'h0;
      drop_count_q <= 32'h0;
    end else begin
      if (!out_valid_q || m_axis.tready) begin
        out_valid_q <= load;
        if (load) begin
          out_tdata_q <= s_axis.tdata;
          out_tstrb_q <= s_axis.tstrb;
          out_tuser_q <= out_tuser_d;
          out_last_q  <= s_axis.tlast;
        end
      end
      if (in_xfer && (state_q == StHeader) && !hdr_drop) begin
        dst_q <= hdr_dst;
      end
      if (in_xfer && s_axis.tlast) begin
        pkt_count_q <= pkt_count_q + 32'd1;
        if (drop_beat) begin
          drop_count_q <= drop_count_q + 32'd1;
        end
      end
    end
  end

  assign s_axis.tready = in_ready;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tdata  = out_tdata_q;
  assign m_axis.tstrb  = out_tstrb_q;
  assign m_axis.tuser  = out_tuser_q;
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_nf10_rx_dst_tagger.sv
// Randomized bench for nf10_rx_dst_tagger with a packet-level reference model and a per-cycle
// compare process, plus directed scenarios with literal expectations.
module tb_nf10_rx_dst_tagger;

  localparam logic [47:0] MAC  = 48'h001122334455;
  localparam logic [7:0]  HOST = 8'h02;
  localparam logic [7:0]  MASK = 8'h55;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        promisc = 1'b0;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  nf10_rx_dst_tagger_if #(.C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128)) s_if ();
  nf10_rx_dst_tagger_if #(.C_AXIS_DATA_WIDTH(256), .C_AXIS_TUSER_WIDTH(128)) m_if ();

  nf10_rx_dst_tagger #(
    .C_AXIS_DATA_WIDTH (256),
    .C_AXIS_TUSER_WIDTH(128),
    .C_MAC_ADDR        (MAC),
    .C_HOST_DST_PORT   (HOST),
    .C_PHYS_PORT_MASK  (MASK)
  ) dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .promisc   (promisc),
    .pkt_count (pkt_count),
    .drop_count(drop_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;
  int rdy_mode = 0;  // 0: hold 1, 1: random, 2: toggle

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit           md_in_pkt, md_drop, md_valid, md_last;
  logic [7:0]   md_dst;
  logic [255:0] md_data;
  logic [31:0]  md_strb;
  logic [127:0] md_user;
  logic [31:0]  md_pkt, md_dropc;

  function automatic logic [7:0] classify(input logic [255:0] d, input logic [127:0] u,
                                          input logic p, output bit drop);
    logic [47:0] m;
    bit          own;
    m    = MAC;
    own  = 1'b1;
    drop = 1'b0;
    for (int i = 0; i < 6; i++) if (d[8*i +: 8] != m[47-8*i -: 8]) own = 1'b0;
    if (d[0]) return HOST | (MASK & ~u[23:16]);
    if (own || p) return HOST;
    drop = 1'b1;
    return 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_in_pkt = 0; md_drop = 0; md_valid = 0; md_last = 0; md_dst = 0;
      md_data = '0; md_strb = '0; md_user = '0; md_pkt = 0; md_dropc = 0;
    end else begin
      bit rdy, acc, fire;
      rdy  = (md_in_pkt && md_drop) || !md_valid || m_if.tready;
      acc  = s_if.tvalid && rdy;
      fire = md_valid && m_if.tready;
      if (fire) md_valid = 0;
      if (acc) begin
        if (!md_in_pkt) begin
          bit d;
          md_dst  = classify(s_if.tdata, s_if.tuser, promisc, d);
          md_drop = d;
        end
        if (!md_drop) begin
          md_valid = 1;
          md_data  = s_if.tdata;
          md_strb  = s_if.tstrb;
          md_user  = s_if.tuser;
          md_user[31:24] = md_dst;
          md_last  = s_if.tlast;
        end
        if (s_if.tlast) begin
          md_pkt++;
          if (md_drop) md_dropc++;
          md_in_pkt = 0;
        end else begin
          md_in_pkt = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("s_tready", s_if.tready, (md_in_pkt && md_drop) || !md_valid || m_if.tready);
      check("m_tvalid", m_if.tvalid, md_valid);
      check("pkt_count", pkt_count, md_pkt);
      check("drop_count", drop_count, md_dropc);
      if (md_valid) begin
        check("m_tdata", m_if.tdata, md_data);
        check("m_tstrb", m_if.tstrb, md_strb);
        check("m_tuser", m_if.tuser, md_user);
        check("m_tlast", m_if.tlast, md_last);
      end
    end
  end

  // ---------------- downstream ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ($urandom_range(0, 3) != 0);
      default: m_if.tready = ~m_if.tready;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic last);
    bit acc;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tstrb  = $urandom;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      acc = s_if.tready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (k > 200) begin
        n_checks++;
        $display("FAIL s_tready_timeout: got 0 for %0d cycles expected 1", k);
        summary();
      end
    end
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind 0: broadcast, 1: own unicast, 2: random multicast, 3: foreign unicast
  function automatic logic [255:0] make_hdr(input int kind);
    logic [255:0] d;
    logic [47:0]  m;
    d = rand256();
    m = MAC;
    case (kind)
      0: d[47:0] = '1;
      1: for (int i = 0; i < 6; i++) d[8*i +: 8] = m[47-8*i -: 8];
      2: d[0] = 1'b1;
      default: begin
        d[0] = 1'b0;
        if (d[47:8] == {m[7:0], m[15:8], m[23:16], m[31:24], m[39:32]}) d[8] = ~d[8];
      end
    endcase
    return d;
  endfunction

  task automatic send_pkt(input int kind, input int len, input logic [7:0] src, input bit rnd);
    logic [127:0] u;
    for (int b = 0; b < len; b++) begin
      u = rand128();
      if (b == 0) u[23:16] = src;
      if (rnd) promisc = $urandom_range(0, 1);
      send_beat((b == 0) ? make_hdr(kind) : rand256(), u, b == len - 1);
      if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] u;
    s_if.tvalid = 0; s_if.tlast = 0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_tvalid", m_if.tvalid, 1'b0);
    check("reset_s_tready", s_if.tready, 1'b1);
    check("reset_m_tuser", m_if.tuser, '0);
    check("reset_pkt_count", pkt_count, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(2);

    // Broadcast 3-beat packet, src 04 -> dst 53 on every beat, 1-cycle latency.
    for (int b = 0; b < 3; b++) begin
      u = rand128();
      u[23:16] = 8'h04;
      send_beat((b == 0) ? make_hdr(0) : rand256(), u, b == 2);
      check("bcast_valid", m_if.tvalid, 1'b1);
      check("bcast_dst", m_if.tuser[31:24], 8'h53);
    end
    check("bcast_pkt_count", pkt_count, 32'd1);

    // Own-MAC unicast 2 beats -> dst 02, remaining tuser bits untouched.
    for (int b = 0; b < 2; b++) begin
      u = rand128();
      send_beat((b == 0) ? make_hdr(1) : rand256(), u, b == 1);
      check("own_dst", m_if.tuser[31:24], 8'h02);
      check("own_tuser_lo", m_if.tuser[23:0], u[23:0]);
      check("own_tuser_hi", m_if.tuser[127:32], u[127:32]);
    end

    // Foreign unicast, promisc 0 -> dropped, input never stalls.
    promisc = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send_beat((b == 0) ? make_hdr(3) : rand256(), rand128(), b == 3);
      check("drop_no_valid", m_if.tvalid, 1'b0);
      check("drop_ready", s_if.tready, 1'b1);
    end
    check("drop_count_1", drop_count, 32'd1);
    check("drop_pkt_count", pkt_count, 32'd3);
    promisc = 1'b1;
    for (int b = 0; b < 4; b++) begin
      send_beat((b == 0) ? make_hdr(3) : rand256(), rand128(), b == 3);
      promisc = 1'b0;  // mid-packet change must not matter
      check("promisc_dst", m_if.tuser[31:24], 8'h02);
    end
    check("promisc_drop_count", drop_count, 32'd1);
    idle(2);

    // Back-to-back single-beat packets with toggling, then steady, ready.
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) send_pkt(i % 3, 1, $urandom, 0);
    rdy_mode = 0;
    for (int i = 0; i < 12; i++) send_pkt(i % 4, 1, $urandom, 0);
    idle(3);

    // Randomized traffic under random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_pkt($urandom_range(0, 3), $urandom_range(1, 5), $urandom, 1);
    end
    idle(4);
    rdy_mode = 0;
    idle(2);

    // Reset during beat 2 of a 5-beat packet.
    promisc = 1'b0;
    send_beat(make_hdr(0), rand128(), 1'b0);
    send_beat(rand256(), rand128(), 1'b0);
    rst = 1'b1;
    #1;
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_m_tdata", m_if.tdata, '0);
    check("rst_m_tuser", m_if.tuser, '0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_drop_count", drop_count, 32'd0);
    check("rst_s_tready", s_if.tready, 1'b1);
    s_if.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    u = rand128();
    u[23:16] = 8'h04;
    send_beat(make_hdr(0), u, 1'b1);
    check("post_rst_hdr_dst", m_if.tuser[31:24], 8'h53);
    check("post_rst_pkt_count", pkt_count, 32'd1);
    idle(2);

    // drop_count wrap.
    #1;
    force dut.drop_count_q = 32'hFFFF_FFFF;
    md_dropc = 32'hFFFF_FFFF;
    #1;
    release dut.drop_count_q;
    @(posedge clk);
    #1;
    check("preload_drop_count", drop_count, 32'hFFFF_FFFF);
    send_pkt(3, 1, 8'h01, 0);
    check("wrap_drop_count", drop_count, 32'd0);
    idle(3);

    summary();
  end

endmodule
